// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, widths, constants.
// Pure declarations, no logic.
// Imported by div32_seq and sub33_bw.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE_ST = 2'b10
    } state_t;

    // Quotient reported for a zero divisor.
    localparam logic [WIDTH-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/sub33_bw.sv
// Combinational W-bit subtractor a - b as a + ~b + 1, with borrow out.
// Zero latency; 4-bit slices with group generate/propagate look-ahead between slices.
// No flow control.
module sub33_bw
    import div_pkg::*;
#(
    parameter int W = WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    // The difference MSB is always 0 when there is no borrow, so only the low bits are returned.
    output logic [W-2:0] diff,
    output logic         borrow
);

    localparam int NS = (W + 3) / 4;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;

    assign g = a & ~b;
    assign p = a ^ ~b;

    // Carry chain: slice carry-outs from group look-ahead, in-slice carries from the slice carry-in.
    always_comb begin
        logic gg;
        logic pp;
        int   base;
        int   top;
        c    = '0;
        c[0] = 1'b1;
        for (int s = 0; s < NS; s++) begin
            base = 4 * s;
            top  = (base + 4 < W) ? base + 4 : W;
            gg   = 1'b0;
            pp   = 1'b1;
            for (int j = 0; j < 4; j++) begin
                if (base + j < W) begin
                    gg = g[base + j] | (p[base + j] & gg);
                    pp = pp & p[base + j];
                end
            end
            for (int j = 0; j < 3; j++) begin
                if (base + j + 1 < top) begin
                    c[base + j + 1] = g[base + j] | (p[base + j] & c[base + j]);
                end
            end
            c[top] = gg | (pp & c[base]);
        end
        diff   = p[W-2:0] ^ c[W-2:0];
        borrow = ~c[W];
    end

endmodule

// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Latency: done 33 cycles after an accepted start (WIDTH steps + completion cycle), 1 cycle for a zero divisor.
// start is ignored while busy; no queueing, no stall of the result.
module div32_seq
    import div_pkg::*;
#(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int CNT_W = div_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CNT_W-1:0] cnt;
    logic             dz_r;

    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] trial;
    logic             borrow;

    // Shift the remainder/quotient pair left by one; the carried-out MSB stays in the partial remainder.
    assign partial = {rem_r, q_r[WIDTH-1]};

    sub33_bw #(
        .W(WIDTH + 1)
    ) u_sub (
        .a      (partial),
        .b      ({1'b0, dvs_r}),
        .diff   (trial),
        .borrow (borrow)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: RUN ends on the completion cycle where the counter sits at WIDTH.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_END) state_nxt = DONE_ST;
            DONE_ST: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE_ST);
    end

    // Datapath: operand capture, restoring step, divide-by-zero shortcut.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r <= '0;
            q_r   <= '0;
            dvs_r <= '0;
            cnt   <= '0;
            dz_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            // Result is known now; park the counter at its end value so only the completion cycle follows.
                            q_r   <= WIDTH'(DZ_QUOT);
                            rem_r <= dividend;
                            dz_r  <= 1'b1;
                            cnt   <= CNT_END;
                        end else begin
                            dvs_r <= divisor;
                            rem_r <= '0;
                            q_r   <= dividend;
                            dz_r  <= 1'b0;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cnt != CNT_END) begin
                        rem_r <= borrow ? partial[WIDTH-1:0] : trial;
                        q_r   <= {q_r[WIDTH-2:0], ~borrow};
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = q_r;
    assign remainder = rem_r;
    assign dz        = dz_r;

endmodule
